ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
- EX-stage control block and consumer end of the ID->EX valid/allowin handshake.
- Accepts id_ex_valid and returns ex_allowin, tracks EX-stage validity, and forwards ex_mem_valid to MEM against mem_allowin.
- Contains a multi-cycle iterative divider that holds ex_ready_go low until the quotient/remainder is ready.
- Operands and control bits come from the ID/EX register and are stable while ex_valid=1 and the instruction has not been handed off.

Parameters:
XLEN, 32, datapath width; divider runs XLEN iterations.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
pipe_flush  in  1  flush; kills the EX instruction and aborts any divide.
id_ex_valid  in  1  ID holds a valid, ready instruction.
ex_allowin  out  1  EX can accept an instruction this cycle.
ex_valid  out  1  EX holds a valid instruction (registered).
mem_allowin  in  1  MEM can accept.
ex_mem_valid  out  1  EX instruction valid and ready to go to MEM.
ex_is_div_inst  in  1  EX instruction is a divide/remainder.
ex_div_sign  in  1  1 = signed, 0 = unsigned.
ex_div_res_sel  in  1  0 = quotient, 1 = remainder.
ex_rs1  in  XLEN  dividend.
ex_rs2  in  XLEN  divisor.
div_result  out  XLEN  selected result; valid when div_done=1.
div_busy  out  1  divider iterating.
div_done  out  1  divide result available.

Behaviour:
- Reset: ex_valid=0, state=IDLE, counter=0, internal registers=0, div_result=0, div_busy=0, div_done=0.
- ex_ready_go = ~ex_is_div_inst | div_done.
- ex_allowin = ~ex_valid | (ex_ready_go & mem_allowin).
- ex_mem_valid = ex_valid & ex_ready_go.
- handoff = ex_mem_valid & mem_allowin.
- ex_valid update priority: rst; then pipe_flush -> 0; else if ex_allowin -> id_ex_valid; else hold.
- Divider FSM states: IDLE, BUSY, DONE.
- IDLE -> DONE when ex_valid & ex_is_div_inst and either divisor==0 or signed overflow. This is the special case; done 1 cycle after entry.
- IDLE -> BUSY on the same start condition otherwise. Latch |rs1| and |rs2| (abs only when signed), record the sign flags, counter=0.
- BUSY: one restoring shift-subtract step per cycle. counter increments; at counter==XLEN-1 go to DONE. div_busy=1 throughout.
- Normal latency: div_done first high XLEN+1 cycles after the start cycle (33 for XLEN=32).
- DONE: div_done=1, div_result held stable. DONE -> IDLE on handoff; hold while mem_allowin=0.
- pipe_flush in any state -> IDLE next cycle; partial result discarded; div_busy and div_done low next cycle.
- Sign fix-up on entry to DONE:
  - quotient negated when signed and operand signs differ;
  - remainder takes the dividend's sign.
- Divide by zero: quotient = all ones, remainder = dividend (signed and unsigned).
- Signed overflow (dividend = 0x80..0, divisor = -1): quotient = dividend, remainder = 0.
- div_result = ex_div_res_sel ? remainder : quotient, registered.
- A new divide cannot start in the cycle of handoff. The FSM returns to IDLE first, and the next instruction starts in the following cycle.
- Non-divide instructions never touch the FSM and pass with zero added latency.
- pipe_flush and handoff in the same cycle: flush wins; ex_valid=0, state=IDLE.

Optional Feature:
- Macro EX_STALL_CNT_EN.
- Defined:
  - adds output ex_stall_cnt [31:0];
  - increments each cycle ex_valid & ~ex_ready_go, and wraps at 2^32;
  - cleared by rst only, not by pipe_flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Non-div pass-through: id_ex_valid=1, ex_is_div_inst=0, mem_allowin=1 -> ex_valid=1 next cycle, ex_mem_valid=1 same cycle, ex_allowin stays 1, no bubbles over 10 back-to-back instructions.
- Unsigned 100/7: div_done after 33 cycles, res_sel=0 -> 14, res_sel=1 -> 2. ex_allowin=0 and ex_mem_valid=0 during BUSY; EX_STALL_CNT_EN build counts 33.
- Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Special cases, each done 1 cycle after start:
  - 5/0 -> quotient 0xFFFFFFFF, remainder 5;
  - signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Flush at BUSY iteration 10 -> next cycle state IDLE, ex_valid=0, div_busy=0. A following 100/7 completes in 33 cycles with the correct result.
- MEM stall: mem_allowin=0 for 5 cycles in DONE -> div_done=1, div_result stable, ex_allowin=0. When mem_allowin=1, handoff occurs and state returns to IDLE.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ---------------------------------------------------------------------------
// ex_div_ctrl
//
// EX-stage control block. It is the consumer end of the ID->EX valid/allowin
// handshake and the producer end of the EX->MEM handshake. It also contains a
// multi-cycle restoring divider. While a divide is in flight the divider
// holds the instruction in EX by keeping ex_ready_go low.
//
// Parameters
//   XLEN            datapath width; the divider runs XLEN iterations.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous reset, active high
//   pipe_flush      kills the EX instruction and aborts any divide
//   id_ex_valid     ID holds a valid instruction ready to move to EX
//   ex_allowin      EX can accept an instruction this cycle
//   ex_valid        EX holds a valid instruction (registered)
//   mem_allowin     MEM can accept an instruction this cycle
//   ex_mem_valid    EX instruction is valid and ready to move to MEM
//   ex_is_div_inst  EX instruction is a divide/remainder
//   ex_div_sign     1 = signed divide, 0 = unsigned
//   ex_div_res_sel  0 = quotient, 1 = remainder
//   ex_rs1          dividend
//   ex_rs2          divisor
//   div_result      selected result, valid while div_done = 1
//   div_busy        divider is iterating
//   div_done        divide result is available
//   ex_stall_cnt    (EX_STALL_CNT_EN only) cycles EX held a stalled
//                   instruction; wraps, cleared only by rst
//
// Build option
//   EX_STALL_CNT_EN  when defined, adds the ex_stall_cnt output and counter.
// ---------------------------------------------------------------------------
module ex_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_flush,
  input  logic            id_ex_valid,
  output logic            ex_allowin,
  output logic            ex_valid,
  input  logic            mem_allowin,
  output logic            ex_mem_valid,
  input  logic            ex_is_div_inst,
  input  logic            ex_div_sign,
  input  logic            ex_div_res_sel,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  output logic [XLEN-1:0] div_result,
  output logic            div_busy,
  output logic            div_done
`ifdef EX_STALL_CNT_EN
  ,
  output logic [31:0]     ex_stall_cnt
`endif
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  div_state_t      state;
  logic [CW-1:0]   counter;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic            neg_quo;
  logic            neg_rem;

  logic            ex_ready_go;
  logic            handoff;

  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;
  logic            div_by_zero;
  logic            div_overflow;

  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            sub_ok;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] quo_fix;

  // Pipeline handshake. A divide is only ready to leave once its result is
  // available; everything else leaves in the cycle it arrives.
  assign ex_ready_go  = ~ex_is_div_inst | div_done;
  assign ex_allowin   = ~ex_valid | (ex_ready_go & mem_allowin);
  assign ex_mem_valid = ex_valid & ex_ready_go;
  assign handoff      = ex_mem_valid & mem_allowin;

  // Operand preparation. Magnitudes are taken only for signed divides so the
  // iterative core always works on unsigned values. The most negative value
  // negates to itself, which is still the correct unsigned magnitude.
  assign rs1_neg      = ex_div_sign & ex_rs1[XLEN-1];
  assign rs2_neg      = ex_div_sign & ex_rs2[XLEN-1];
  assign rs1_abs      = rs1_neg ? -ex_rs1 : ex_rs1;
  assign rs2_abs      = rs2_neg ? -ex_rs2 : ex_rs2;
  assign div_by_zero  = (ex_rs2 == '0);
  assign div_overflow = ex_div_sign & (ex_rs1 == INT_MIN) & (ex_rs2 == '1);

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. The extra top bit of the
  // difference is the borrow, so a clear top bit means the subtraction fits.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor_q};
  assign sub_ok    = ~rem_diff[XLEN];
  assign rem_next  = sub_ok ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign quo_next  = {quo_q[XLEN-2:0], sub_ok};

  // Sign fix-up applied to the final step's result as the FSM enters DONE.
  assign quo_fix = neg_quo ? -quo_next : quo_next;
  assign rem_fix = neg_rem ? -rem_next : rem_next;

  // EX-stage valid bit. Flush outranks the handshake so a killed instruction
  // never lingers, even if MEM would have taken it this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
    end else if (pipe_flush) begin
      ex_valid <= 1'b0;
    end else if (ex_allowin) begin
      ex_valid <= id_ex_valid;
    end
  end

  // Divider FSM with registered status and result. Division by zero and
  // signed overflow have fixed answers, so they skip the iteration and land
  // in DONE one cycle after the start. DONE is left only through a handoff,
  // which guarantees one IDLE cycle before the next divide can start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      counter    <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      div_result <= '0;
      div_busy   <= 1'b0;
      div_done   <= 1'b0;
    end else if (pipe_flush) begin
      state    <= IDLE;
      counter  <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid & ex_is_div_inst) begin
            if (div_by_zero | div_overflow) begin
              state    <= DONE;
              div_done <= 1'b1;
              if (ex_div_res_sel) begin
                div_result <= div_by_zero ? ex_rs1 : '0;
              end else begin
                div_result <= div_by_zero ? '1 : ex_rs1;
              end
            end else begin
              state     <= BUSY;
              div_busy  <= 1'b1;
              counter   <= '0;
              divisor_q <= rs2_abs;
              quo_q     <= rs1_abs;
              rem_q     <= '0;
              neg_quo   <= rs1_neg ^ rs2_neg;
              neg_rem   <= rs1_neg;
            end
          end
        end

        BUSY: begin
          quo_q   <= quo_next;
          rem_q   <= rem_next;
          counter <= counter + CW'(1);
          if (counter == CNT_LAST) begin
            state      <= DONE;
            div_busy   <= 1'b0;
            div_done   <= 1'b1;
            div_result <= ex_div_res_sel ? rem_fix : quo_fix;
          end
        end

        DONE: begin
          if (handoff) begin
            state    <= IDLE;
            div_done <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          div_busy <= 1'b0;
          div_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef EX_STALL_CNT_EN
  // Performance counter of cycles in which EX holds an instruction that is
  // not ready to leave. It survives flushes on purpose so it measures the
  // whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_stall_cnt <= '0;
    end else if (ex_valid & ~ex_ready_go) begin
      ex_stall_cnt <= ex_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_div_ctrl
//
// Bench for ex_div_ctrl. A driver acts as the ID stage plus ID/EX register:
// each accepted instruction is loaded onto the ex_* inputs and its expected
// outcome (result and divide latency) is pushed into a scoreboard queue. A
// separate monitor follows the EX stage every cycle and pops the scoreboard
// on handoff or flush. Expected values come from plain integer division with
// the architectural divide-by-zero and overflow rules.
// ---------------------------------------------------------------------------
module tb_ex_div_ctrl;

  localparam int XLEN = 32;
  localparam int NORMAL_LAT = XLEN + 1;

  typedef struct {
    bit          is_div;
    bit          sgn;
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
  } instr_t;

  typedef struct {
    bit          is_div;
    logic [31:0] result;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_flush = 1'b0;
  logic        id_ex_valid = 1'b0;
  logic        ex_allowin;
  logic        ex_valid;
  logic        mem_allowin = 1'b1;
  logic        ex_mem_valid;
  logic        ex_is_div_inst = 1'b0;
  logic        ex_div_sign = 1'b0;
  logic        ex_div_res_sel = 1'b0;
  logic [31:0] ex_rs1 = '0;
  logic [31:0] ex_rs2 = '0;
  logic [31:0] div_result;
  logic        div_busy;
  logic        div_done;
`ifdef EX_STALL_CNT_EN
  logic [31:0] ex_stall_cnt;
`endif

  int      tests_run = 0;
  int      tests_failed = 0;
  instr_t  pend_q[$];
  exp_t    sb_q[$];

  int      cyc = 0;
  bit      tracking = 0;
  bit      done_seen = 0;
  int      entry_cyc = 0;
  exp_t    cur;
  bit      chk_flush = 0;
  bit      chk_idle = 0;
  int      handoffs = 0;
  longint  stall_model = 0;

  ex_div_ctrl #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_flush    (pipe_flush),
    .id_ex_valid   (id_ex_valid),
    .ex_allowin    (ex_allowin),
    .ex_valid      (ex_valid),
    .mem_allowin   (mem_allowin),
    .ex_mem_valid  (ex_mem_valid),
    .ex_is_div_inst(ex_is_div_inst),
    .ex_div_sign   (ex_div_sign),
    .ex_div_res_sel(ex_div_res_sel),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .div_result    (div_result),
    .div_busy      (div_busy),
    .div_done      (div_done)
`ifdef EX_STALL_CNT_EN
    ,
    .ex_stall_cnt  (ex_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural divide result.
  function automatic logic [31:0] refDiv(bit sgn, bit sel, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return sel ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return sel ? 32'd0 : a;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return sel ? r[31:0] : q[31:0];
  endfunction

  function automatic int refLat(instr_t it);
    if (!it.is_div) return 0;
    if (it.b == 32'd0) return 1;
    if (it.sgn && it.a == 32'h8000_0000 && it.b == 32'hFFFF_FFFF) return 1;
    return NORMAL_LAT;
  endfunction

  task automatic pushInstr(bit is_div, bit sgn, bit sel, logic [31:0] a, logic [31:0] b);
    instr_t it;
    it.is_div = is_div;
    it.sgn    = sgn;
    it.sel    = sel;
    it.a      = a;
    it.b      = b;
    pend_q.push_back(it);
  endtask

  // One clock of ID-side driving. Acceptance is judged just before the edge;
  // the accepted instruction becomes the EX instruction right after it.
  task automatic applyStimulus(input bit flush_now, input bit mem_rdy);
    bit     accept;
    instr_t it;
    exp_t   e;
    pipe_flush  = flush_now;
    mem_allowin = mem_rdy;
    id_ex_valid = (pend_q.size() != 0);
    @(negedge clk);
    accept = id_ex_valid & ex_allowin & ~pipe_flush;
    @(posedge clk);
    #1;
    pipe_flush = 1'b0;
    if (accept) begin
      it = pend_q.pop_front();
      ex_is_div_inst = it.is_div;
      ex_div_sign    = it.sgn;
      ex_div_res_sel = it.sel;
      ex_rs1         = it.a;
      ex_rs2         = it.b;
      e.is_div = it.is_div;
      e.result = it.is_div ? refDiv(it.sgn, it.sel, it.a, it.b) : 32'd0;
      e.lat    = refLat(it);
      sb_q.push_back(e);
    end
  endtask

  task automatic runPhase(input string name, input int mem_pct, input int flush_pct, input int max_cycles);
    int n = 0;
    while ((pend_q.size() != 0 || sb_q.size() != 0) && n < max_cycles) begin
      applyStimulus($urandom_range(0, 99) < flush_pct, $urandom_range(0, 99) < mem_pct);
      n++;
    end
    if (pend_q.size() != 0 || sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_timeout: %0d instructions outstanding after %0d cycles", name,
               pend_q.size() + sb_q.size(), n);
      pend_q.delete();
      applyStimulus(1'b1, 1'b1);
      sb_q.delete();
    end
  endtask

  task automatic genRandom(input int n);
    repeat (n) begin
      bit          is_div, sgn, sel;
      logic [31:0] a, b;
      is_div = ($urandom_range(0, 99) >= 35);
      sgn    = 1'($urandom_range(0, 1));
      sel    = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = b >> $urandom_range(1, 31);
        4: a = a >> $urandom_range(1, 31);
        5: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      pushInstr(is_div, sgn, sel, a, b);
    end
  endtask

  // Monitor: follows the EX instruction from entry to handoff or flush and
  // compares against the scoreboard head.
  always @(negedge clk) begin
    int k;
    cyc++;
    if (!rst) begin
      if (chk_flush) begin
        checkOutput("flush_clears", {29'd0, ex_valid, div_busy, div_done}, 32'd0);
        chk_flush = 0;
      end
      if (chk_idle) begin
        checkOutput("idle_after_handoff", {31'd0, div_done}, 32'd0);
        chk_idle = 0;
      end
      if (ex_valid && !tracking) begin
        tracking  = 1;
        done_seen = 0;
        entry_cyc = cyc;
        if (sb_q.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
          cur = '{is_div: 1'b0, result: 32'd0, lat: 0};
        end else begin
          cur = sb_q[0];
        end
        if (!cur.is_div) begin
          checkOutput("nondiv_ready", {31'd0, ex_mem_valid}, 32'd1);
          checkOutput("nondiv_allowin", {31'd0, ex_allowin}, {31'd0, mem_allowin});
        end
      end
      if (tracking && cur.is_div) begin
        if (div_done) begin
          if (!done_seen) begin
            done_seen = 1;
            checkOutput("div_latency", 32'(cyc - entry_cyc), 32'(cur.lat));
          end
          checkOutput("div_result", div_result, cur.result);
          checkOutput("done_allowin", {31'd0, ex_allowin}, {31'd0, mem_allowin});
        end else if (cyc != entry_cyc) begin
          checkOutput("busy_stall", {29'd0, div_busy, ex_allowin, ex_mem_valid}, 32'd4);
        end
      end
      if (pipe_flush) begin
        chk_flush = 1;
        if (tracking) begin
          k = cyc - entry_cyc + 1;
          stall_model += (k < cur.lat) ? k : cur.lat;
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          tracking = 0;
        end
      end else if (tracking && ex_mem_valid && mem_allowin) begin
        stall_model += cur.lat;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        tracking = 0;
        handoffs++;
        if (cur.is_div) chk_idle = 1;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_ex_allowin", {31'd0, ex_allowin}, 32'd1);
    checkOutput("rst_ex_mem_valid", {31'd0, ex_mem_valid}, 32'd0);
    checkOutput("rst_div_busy", {31'd0, div_busy}, 32'd0);
    checkOutput("rst_div_done", {31'd0, div_done}, 32'd0);
    checkOutput("rst_div_result", div_result, 32'd0);
`ifdef EX_STALL_CNT_EN
    checkOutput("rst_stall_cnt", ex_stall_cnt, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ten back-to-back non-divide instructions with MEM always ready.
    for (int i = 0; i < 10; i++) pushInstr(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    h0 = handoffs;
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("b2b_handoffs", 32'(handoffs - h0), 32'd10);
    runPhase("b2b", 100, 0, 50);

    // Directed divides, including the special cases.
    pushInstr(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    pushInstr(1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
    pushInstr(1'b1, 1'b1, 1'b0, -32'sd7, 32'd2);
    pushInstr(1'b1, 1'b1, 1'b1, -32'sd7, 32'd2);
    pushInstr(1'b1, 1'b1, 1'b0, 32'd7, -32'sd2);
    pushInstr(1'b1, 1'b1, 1'b1, 32'd7, -32'sd2);
    pushInstr(1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
    pushInstr(1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
    pushInstr(1'b1, 1'b1, 1'b1, -32'sd5, 32'd0);
    pushInstr(1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    pushInstr(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    pushInstr(1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    pushInstr(1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
    runPhase("directed", 100, 0, 1000);

    // MEM stall: result held for five cycles in DONE before MEM accepts.
    pushInstr(1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
    for (int i = 0; i < 39; i++) applyStimulus(1'b0, 1'b0);
    h0 = handoffs;
    applyStimulus(1'b0, 1'b1);
    checkOutput("mem_stall_handoff", 32'(handoffs - h0), 32'd1);
    runPhase("mem_stall", 100, 0, 100);

    // Flush at BUSY iteration 10, then a clean 100/7.
    pushInstr(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 14; i++) applyStimulus(i == 12, 1'b1);
    pushInstr(1'b1, 1'b0, 1'b0, 32'd100, 32'd7);
    runPhase("after_flush", 100, 0, 100);

    // Randomized traffic with MEM back-pressure and occasional flushes.
    genRandom(150);
    runPhase("random", 70, 2, 20000);

    repeat (3) applyStimulus(1'b0, 1'b1);
`ifdef EX_STALL_CNT_EN
    checkOutput("stall_cnt", ex_stall_cnt, 32'(stall_model));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
